// File: rtl/ex_mul_pkg.sv
// Shared widths, opcode encodings and multiplier FSM states for the execute stage.
// Optional build macro used by this block: EX_MUL_EARLY_OUT_EN.
package ex_mul_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b0001_1001;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [AluSelBus-1:0] EXE_RES_MUL   = 3'b101;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Magnitude as 32-bit unsigned, so 0x80000000 stays 2^31.
    function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v, input logic sgn);
        abs32 = (sgn && v[RegBus-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_mul_mul_iter.sv
// Iterative shift-add 32x32->64 multiplier: IDLE -> RUN (ITER cycles, or early exit
// under EX_MUL_EARLY_OUT_EN) -> DONE, product valid while done=1.
module mul_iter
    import ex_mul_pkg::*;
#(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    localparam int ITER = 32 / MUL_BITS;

    mul_state_e  state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        count_d  = count_q;
        acc_sum  = acc_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = {32'h0, abs32(a, signed_op)};
                    mplier_d = abs32(b, signed_op);
                    neg_d    = signed_op & (a[31] ^ b[31]);
                    acc_d    = 64'h0;
                    count_d  = 6'd0;
                    state_d  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                for (int i = 0; i < MUL_BITS; i++) begin
                    if (mplier_q[i]) acc_sum = acc_sum + (mcand_q << i);
                end
                acc_d    = acc_sum;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                count_d  = count_q + 6'd1;
`ifdef EX_MUL_EARLY_OUT_EN
                // Remaining multiplier bits all zero: further steps add nothing.
                if (mplier_d == 32'h0 || count_q == 6'(ITER - 1)) state_d = MUL_DONE;
`else
                if (count_q == 6'(ITER - 1)) state_d = MUL_DONE;
`endif
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= 64'h0;
            mplier_q <= 32'h0;
            acc_q    <= 64'h0;
            neg_q    <= 1'b0;
            count_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            count_q  <= count_d;
        end
    end

    assign busy    = (state_q == MUL_RUN);
    assign done    = (state_q == MUL_DONE);
    assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/ex_mul.sv
// MIPS32 execute stage: logic/shift/move results, HI/LO registers and an iterative MULT/MULTU
// that stalls the pipeline. Build macro EX_MUL_EARLY_OUT_EN enables multiplier early exit.
module ex_mul
    import ex_mul_pkg::*;
#(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] result;
    logic        is_mult, mul_start, mul_busy, mul_done;
    logic [63:0] mul_product;

    assign is_mult   = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    // DONE is excluded so the still-held multiply is not restarted.
    assign mul_start = is_mult & ~mul_busy & ~mul_done;

    mul_iter #(.MUL_BITS(MUL_BITS)) u_mul_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .signed_op (aluop_i == EXE_MULT_OP),
        .a         (reg1_i),
        .b         (reg2_i),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        result = ZeroWord;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  result = reg1_i | reg2_i;
                    EXE_AND_OP: result = reg1_i & reg2_i;
                    EXE_XOR_OP: result = reg1_i ^ reg2_i;
                    EXE_NOR_OP: result = ~(reg1_i | reg2_i);
                    default:    result = ZeroWord;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
                    EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
                    EXE_SRA_OP: result = $signed(reg2_i) >>> reg1_i[4:0];
                    default:    result = ZeroWord;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: result = hi_q;
                    EXE_MFLO_OP: result = lo_q;
                    default:     result = ZeroWord;
                endcase
            end
            default: result = ZeroWord;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_done) begin
            hi_d = mul_product[63:32];
            lo_d = mul_product[31:0];
        end else if (aluop_i == EXE_MTHI_OP) begin
            hi_d = reg1_i;
        end else if (aluop_i == EXE_MTLO_OP) begin
            lo_d = reg1_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = result;
        hi_o       = hi_q;
        lo_o       = lo_q;
        stallreq_o = mul_start | mul_busy;
        if (is_mult || aluop_i == EXE_MTHI_OP || aluop_i == EXE_MTLO_OP) wreg_o = WriteDisable;
        if (rst == RstEnable) begin
            wd_o       = 5'd0;
            wreg_o     = WriteDisable;
            wdata_o    = ZeroWord;
            hi_o       = ZeroWord;
            lo_o       = ZeroWord;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mul.sv
// Directed-vector bench for ex_mul: ALU results, HI/LO moves, multiply latency/results, reset abort.
module tb_ex_mul;
    import ex_mul_pkg::*;

`ifdef EX_MUL_EARLY_OUT_EN
    localparam int ST_SHORT = 3;
`else
    localparam int ST_SHORT = 33;
`endif
    localparam int ST_FULL = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'h0;
    logic [2:0]  alusel_i = 3'h0;
    logic [31:0] reg1_i = 32'h0, reg2_i = 32'h0;
    logic [4:0]  wd_i = 5'h0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;
    int n;

    ex_mul #(.MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr);
        @(posedge clk);
        #1;
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wr;
    endtask

    // Counts stall cycles of a multiply already driven; returns on the DONE cycle.
    task automatic run_mul(input string tag, output int cnt);
        logic wreg_seen;
        wreg_seen = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            wreg_seen = wreg_seen | wreg_o;
            if (!stallreq_o) break;
            cnt++;
        end
        chk({tag, "_wreg"}, {63'h0, wreg_seen}, 64'h0);
    endtask

    initial begin
        // Reset: outputs forced low even with a live OR instruction on the inputs.
        aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC;
        reg1_i = 32'h0000_FF00; reg2_i = 32'h00F0_F0F0; wd_i = 5'd3; wreg_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wdata", {32'h0, wdata_o}, 64'h0);
        chk("rst_wreg", {63'h0, wreg_o}, 64'h0);
        chk("rst_stall", {63'h0, stallreq_o}, 64'h0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("or_wdata", {32'h0, wdata_o}, 64'h00F0_FFF0);
        chk("or_wd", {59'h0, wd_o}, 64'd3);
        chk("or_wreg", {63'h0, wreg_o}, 64'd1);
        chk("or_stall", {63'h0, stallreq_o}, 64'h0);

        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
        @(negedge clk); chk("sra", {32'h0, wdata_o}, 64'hF800_0001);
        drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
        @(negedge clk); chk("srl", {32'h0, wdata_o}, 64'h0800_0001);
        drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd8, 32'h8000_0013, 5'd4, 1'b1);
        @(negedge clk); chk("sll", {32'h0, wdata_o}, 64'h0000_1300);
        drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_000F, 5'd4, 1'b1);
        @(negedge clk); chk("nor", {32'h0, wdata_o}, 64'h0F0F_FFF0);
        drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd4, 1'b1);
        @(negedge clk); chk("xor", {32'h0, wdata_o}, 64'hF0F0_F0F0);

        // Signed -2 * 3
        drive(EXE_MULT_OP, EXE_RES_MUL, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
        run_mul("mult", n);
        chk("mult_stall", n, ST_SHORT);
        drive(8'h0, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk); chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);

        // Unsigned full-width, then MFLO must see the new LO immediately.
        drive(EXE_MULTU_OP, EXE_RES_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);
        run_mul("multu", n);
        chk("multu_stall", n, ST_FULL);
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        chk("mflo_wdata", {32'h0, wdata_o}, 64'h1);
        chk("mflo_wd", {59'h0, wd_o}, 64'd5);
        chk("mflo_wreg", {63'h0, wreg_o}, 64'd1);
        chk("multu_hi", {32'h0, hi_o}, 64'hFFFF_FFFE);

        drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0, 5'd0, 1'b1);
        @(negedge clk); chk("mthi_wreg", {63'h0, wreg_o}, 64'h0);
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd7, 1'b1);
        @(negedge clk); chk("mfhi", {32'h0, wdata_o}, 64'h1234_5678);
        drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFE_0001, 32'h0, 5'd0, 1'b1);
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd7, 1'b1);
        @(negedge clk); chk("mflo2", {32'h0, wdata_o}, 64'hCAFE_0001);

        // Abort a long multiply in RUN with a reset pulse.
        drive(EXE_MULTU_OP, EXE_RES_MUL, 32'd5, 32'hFFFF_FFFF, 5'd0, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        aluop_i = 8'h0; alusel_i = EXE_RES_NOP; wreg_i = 1'b0;
        @(negedge clk); chk("abort_rst_stall", {63'h0, stallreq_o}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", {63'h0, stallreq_o}, 64'h0);
        chk("abort_hilo", {hi_o, lo_o}, 64'h0);

        // Fresh multiply after abort; short multiplier exercises early exit when built in.
        drive(EXE_MULTU_OP, EXE_RES_MUL, 32'd7, 32'd2, 5'd0, 1'b1);
        run_mul("m7x2", n);
        chk("m7x2_stall", n, ST_SHORT);
        drive(8'h0, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk); chk("m7x2_hilo", {hi_o, lo_o}, 64'd14);

        // Most negative operand: magnitude 2^31 must survive as unsigned.
        drive(EXE_MULT_OP, EXE_RES_MUL, 32'h8000_0000, 32'd2, 5'd0, 1'b1);
        run_mul("mneg", n);
        chk("mneg_stall", n, ST_SHORT);
        drive(8'h0, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk); chk("mneg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
